// File: rtl/recirc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : recirc_ctrl_pkg
// Description : Shared definitions for the recirculation controller: the
//               FSM state encoding and the default word width.
// Revision    : 1.0 - initial release
// ============================================================================
package recirc_ctrl_pkg;

  // The encoding is visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_STALL = 2'd3
  } state_e;

  localparam int unsigned C_DATA_W_DEF = 32;

  // RUN and STALL are the states in which words may move.
  function automatic logic is_operational(input state_e s);
    return (s == ST_RUN) || (s == ST_STALL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/recirc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : recirc_fifo
// Description : Small synchronous in-order FIFO holding recirculated words.
//               Head word is presented combinationally from the read pointer.
// Revision    : 1.0 - initial release
// Ports       : clk_i        clock, rising edge
//               reset_i      asynchronous active-high reset (empties FIFO)
//               flush_i      synchronous flush, overrides push/pop
//               push_i       write push_data_i (caller guarantees !full)
//               push_data_i  word to store
//               pop_i        drop head word (caller guarantees !empty)
//               head_o       current head word
//               full_o       all FIFO_DEPTH entries occupied
//               empty_o      no entries occupied
// ============================================================================
module recirc_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4      // power of two, >= 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // One extra pointer bit distinguishes full from empty when the index bits match.
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

endmodule
`default_nettype wire

// File: rtl/recirc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : recirc_ctrl
// Description : Sequencing controller for the recirculation demux ahead of
//               the striping stage. Selects forward/recirculate, picks the
//               demux input word, holds returned words in order and replays
//               them ahead of new input. Handles bring-up and stall health.
// Revision    : 1.0 - initial release
// Ports       : clk_i           clock, rising edge
//               reset_i         asynchronous active-high reset
//               init_i          bring-up (re)start pulse
//               in_valid_i      upstream word present
//               in_data_i       upstream word
//               in_ready_o      upstream word accepted when valid & ready
//               stripe_ready_i  striping stage can take a word
//               active_o        demux select: 1 forward, 0 recirculate
//               mux_data_o      demux din
//               block_data_i    demux out_block (returned word)
//               state_o         RESET=0 INIT=1 RUN=2 STALL=3
//               recirc_count_o  saturating recirculation counter
//               stall_err_o     sticky stall timeout
// ============================================================================
module recirc_ctrl
  import recirc_ctrl_pkg::*;
#(
  parameter int DATA_W      = C_DATA_W_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int INIT_CYCLES = 4,    // 1..256
  parameter int MAX_STALL   = 15    // 1..255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              init_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  input  logic              stripe_ready_i,
  output logic              active_o,
  output logic [DATA_W-1:0] mux_data_o,
  input  logic [DATA_W-1:0] block_data_i,
  output logic [1:0]        state_o,
  output logic [7:0]        recirc_count_o,
  output logic              stall_err_o
);

  localparam logic [7:0] C_INIT_LAST  = 8'(INIT_CYCLES - 1);
  localparam logic [7:0] C_STALL_LAST = 8'(MAX_STALL - 1);

  state_e      state_q;
  logic [7:0]  init_cnt_q;
  logic [7:0]  stall_cnt_q;
  logic [7:0]  recirc_cnt_q;
  logic        stall_err_q;

  logic              w_op;
  logic              w_present;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_push_data_d;

  assign w_op      = is_operational(state_q);
  assign w_present = !w_empty || in_valid_i;

  assign active_o   = w_op && w_present && stripe_ready_i;
  // Held words always go before new input to keep order.
  assign mux_data_o = (w_op && w_present) ? (w_empty ? in_data_i : w_head) : '0;
  // Deliberately ignores a same-cycle pop so the full check stays registered-only.
  assign in_ready_o = w_op && !w_full;

  assign w_pop   = active_o && !w_empty;
  // An accepted word is held unless it went straight through the demux.
  assign w_push  = in_valid_i && in_ready_o && !(w_empty && stripe_ready_i);
  // When empty the input word itself was on din and came back via out_block.
  assign w_push_data_d = w_empty ? block_data_i : in_data_i;
  assign w_flush = w_op && init_i;

  recirc_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .flush_i     (w_flush),
    .push_i      (w_push),
    .push_data_i (w_push_data_d),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_RESET;
      init_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      recirc_cnt_q <= '0;
      stall_err_q  <= 1'b0;
    end else begin
      if (w_op && w_present && !stripe_ready_i && (recirc_cnt_q != 8'hFF))
        recirc_cnt_q <= recirc_cnt_q + 8'd1;

      case (state_q)
        ST_RESET: begin
          if (init_i) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
          end
        end
        ST_INIT: begin
          if (init_i)                        init_cnt_q <= '0;
          else if (init_cnt_q == C_INIT_LAST) state_q   <= ST_RUN;
          else                               init_cnt_q <= init_cnt_q + 8'd1;
        end
        ST_RUN: begin
          if (!init_i && w_full && !stripe_ready_i) state_q <= ST_STALL;
        end
        ST_STALL: begin
          if (!init_i) begin
            if (stripe_ready_i) begin
              state_q     <= ST_RUN;
              stall_cnt_q <= '0;
            end else begin
              if (stall_cnt_q != 8'hFF)        stall_cnt_q <= stall_cnt_q + 8'd1;
              if (stall_cnt_q == C_STALL_LAST) stall_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_RESET;
      endcase

      // Restart from RUN/STALL wins over everything above.
      if (w_op && init_i) begin
        state_q      <= ST_INIT;
        init_cnt_q   <= '0;
        stall_cnt_q  <= '0;
        recirc_cnt_q <= '0;
        stall_err_q  <= 1'b0;
      end
    end
  end

  assign state_o        = state_q;
  assign recirc_count_o = recirc_cnt_q;
  assign stall_err_o    = stall_err_q;

endmodule
`default_nettype wire

// File: tb/tb_recirc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_recirc_ctrl
// Description : Self-checking bench for recirc_ctrl. Accepted words are
//               queued as expected output; a monitor pops and compares on
//               every forwarded word. Directed phase checks use hand-computed
//               values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_recirc_ctrl;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              init;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              stripe_ready;
  logic              active;
  logic [DATA_W-1:0] mux_data;
  logic [DATA_W-1:0] block_data;
  logic [1:0]        state;
  logic [7:0]        recirc_count;
  logic              stall_err;

  int n_vec = 0;
  int n_err = 0;
  logic [DATA_W-1:0] sb[$];

  always #5 clk = ~clk;

  // Demux model: a word not forwarded comes back on out_block.
  assign block_data = active ? '0 : mux_data;

  recirc_ctrl #(
    .DATA_W(DATA_W), .FIFO_DEPTH(4), .INIT_CYCLES(4), .MAX_STALL(15)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .init_i         (init),
    .in_valid_i     (in_valid),
    .in_data_i      (in_data),
    .in_ready_o     (in_ready),
    .stripe_ready_i (stripe_ready),
    .active_o       (active),
    .mux_data_o     (mux_data),
    .block_data_i   (block_data),
    .state_o        (state),
    .recirc_count_o (recirc_count),
    .stall_err_o    (stall_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word for one clock; queue it as expected output if accepted.
  task automatic send(input logic [DATA_W-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    #1;
    if (in_ready) sb.push_back(w);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every forwarded word must be the oldest outstanding accepted word.
  initial begin
    logic [DATA_W-1:0] exp_w;
    forever begin
      @(negedge clk);
      #1;
      if (active) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", mux_data, 32'hFFFF_FFFF);
        end else begin
          exp_w = sb.pop_front();
          chk("out_word", mux_data, exp_w);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; init = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD;
    stripe_ready = 1'b1;

    // Reset state, with a word offered to confirm outputs stay quiet.
    #12;
    chk("rst_state",    32'(state), 32'd0);
    chk("rst_active",   32'(active), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mux_data", mux_data, 32'd0);
    chk("rst_recirc",   32'(recirc_count), 32'd0);
    chk("rst_stall_err",32'(stall_err), 32'd0);
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("idle_state", 32'(state), 32'd0);

    // Bring-up: exactly four INIT cycles, then RUN with in_ready high.
    init = 1'b1;
    step();
    init = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("init_state", 32'(state), 32'd1);
      chk("init_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    chk("run_state", 32'(state), 32'd2);
    chk("run_in_ready", 32'(in_ready), 32'd1);

    // Direct path: zero latency, forwarded in the same cycle.
    stripe_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(i);
      #1;
      chk("direct_active", 32'(active), 32'd1);
      chk("direct_mux", mux_data, 32'hA0 + 32'(i));
      if (in_ready) sb.push_back(in_data);
      step();
    end
    in_valid = 1'b0;
    chk("direct_recirc", 32'(recirc_count), 32'd0);
    drain(4);

    // Recirculation order: three held words precede the new one.
    stripe_ready = 1'b0;
    send(32'h11);
    send(32'h22);
    send(32'h33);
    chk("recirc_hold_active", 32'(active), 32'd0);
    stripe_ready = 1'b1;
    send(32'h44);
    drain(8);
    chk("recirc_count3", 32'(recirc_count), 32'd3);

    // Full and stall: four words fill the FIFO, then STALL and timeout.
    stripe_ready = 1'b0;
    send(32'h51);
    send(32'h52);
    send(32'h53);
    send(32'h54);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_state_run", 32'(state), 32'd2);
    step();
    chk("stall_state", 32'(state), 32'd3);
    for (int i = 0; i < 14; i++) step();
    chk("stall_err_early", 32'(stall_err), 32'd0);
    step();
    chk("stall_err_set", 32'(stall_err), 32'd1);
    chk("stall_recirc", 32'(recirc_count), 32'd23);
    stripe_ready = 1'b1;
    #1;
    chk("pop_full_in_ready", 32'(in_ready), 32'd0);
    chk("pop_full_active", 32'(active), 32'd1);
    step();
    chk("unstall_state", 32'(state), 32'd2);
    chk("stall_err_sticky", 32'(stall_err), 32'd1);
    drain(8);

    // Restart with two held words: everything cleared, INIT again.
    stripe_ready = 1'b0;
    send(32'h61);
    send(32'h62);
    init = 1'b1;
    step();
    init = 1'b0;
    sb.delete();
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_recirc", 32'(recirc_count), 32'd0);
    chk("restart_stall_err", 32'(stall_err), 32'd0);
    for (int i = 0; i < 3; i++) step();
    chk("restart_init_last", 32'(state), 32'd1);
    step();
    chk("restart_run", 32'(state), 32'd2);
    stripe_ready = 1'b1;
    #1;
    chk("restart_fifo_empty_active", 32'(active), 32'd0);
    chk("restart_fifo_empty_mux", mux_data, 32'd0);
    chk("restart_in_ready", 32'(in_ready), 32'd1);
    step();

    // Async reset between edges while a word is being forwarded.
    in_valid = 1'b1;
    in_data  = 32'h77;
    #1;
    chk("pre_reset_active", 32'(active), 32'd1);
    if (in_ready) sb.push_back(in_data);
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_active", 32'(active), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    chk("async_mux", mux_data, 32'd0);
    chk("async_state", 32'(state), 32'd0);
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("post_reset_state", 32'(state), 32'd0);
    chk("post_reset_sb", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
